// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: drives the imem pc, registers the returned word and hands it to
// decode over valid/ready, with redirect, end-of-program and bad-target fault handling.
module instr_fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_pc,
  input  logic [31:0]      imem_instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [31:0] MemBytes = 32'(MEM_BYTES);
  localparam logic [31:0] ResetPc  = 32'(RESET_PC);

  typedef enum logic [2:0] {StBoot, StFetch, StDrain, StHalt, StFault} state_e;

  state_e           state_q;
  logic [31:0]      pc_q;
  logic             valid_q;
  logic [31:0]      instr_q;
  logic [31:0]      instr_pc_q;
  logic             halted_q;
  logic             fault_q;
  logic [CNT_W-1:0] count_q;

  logic [31:0] pc_inc;
  logic        last_word;
  logic        handshake;
  logic        capture;
  logic        bad_target;
  logic        count_full;

  always_comb begin
    pc_inc     = pc_q + 32'd4;
    last_word  = (pc_inc == MemBytes);
    handshake  = valid_q && instr_ready;
    capture    = !valid_q || instr_ready;
    bad_target = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= MemBytes);
    count_full = (count_q == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= ResetPc;
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      unique case (state_q)
        StBoot:  state_q <= StFetch;
        StFault: ;
        default: begin
          if (redirect_valid) begin
            // The held word is dropped even if decode accepts it this same cycle.
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            if (bad_target) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= redirect_pc;
              state_q <= StFetch;
            end
          end else begin
            if (handshake && !count_full) begin
              count_q <= count_q + 1'b1;
            end
            if (state_q == StFetch && capture) begin
              instr_q    <= imem_instr;
              instr_pc_q <= pc_q;
              valid_q    <= 1'b1;
              // pc parks on the final word rather than stepping past the end of memory.
              if (last_word) begin
                state_q <= StDrain;
              end else begin
                pc_q <= pc_inc;
              end
            end else if (state_q == StDrain && handshake) begin
              valid_q  <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end
          end
        end
      endcase
    end
  end

  assign imem_pc     = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with literal expectations plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_ctrl;

  localparam int unsigned MemBytes = 32;
  localparam int unsigned CntW     = 4;

  logic            clk;
  logic            reset;
  logic [31:0]     imem_pc;
  logic [31:0]     imem_instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [31:0]     instr_pc;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            halted;
  logic            fault;
  logic [CntW-1:0] fetch_count;

  logic [31:0] words [8];
  int checks = 0;
  int passes = 0;

  instr_fetch_ctrl #(.MEM_BYTES(MemBytes), .RESET_PC(0), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted), .fault(fault),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_instr = words[imem_pc[4:2]];

  // Reference model: next address to fetch, the word held for decode, and program status.
  bit              m_boot = 1'b1;
  bit              m_have, m_all, m_halt, m_fault;
  logic [31:0]     m_next = 32'd0;
  logic [31:0]     m_wpc  = 32'd0;
  logic [CntW-1:0] m_count = '0;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= MemBytes);
  endfunction

  task automatic model_step();
    bit hs;
    if (reset) begin
      m_boot = 1; m_next = 0; m_have = 0; m_wpc = 0; m_all = 0;
      m_halt = 0; m_fault = 0; m_count = '0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_fault) begin
      if (redirect_valid) begin
        m_have = 0; m_halt = 0;
        if (bad_addr(redirect_pc)) m_fault = 1;
        else begin m_next = redirect_pc; m_all = 0; end
      end else begin
        hs = m_have && instr_ready;
        if (hs && m_count != '1) m_count = m_count + 1'b1;
        if (!m_all && (!m_have || instr_ready)) begin
          m_wpc = m_next; m_have = 1;
          if (m_next + 4 == MemBytes) m_all = 1;
          else m_next = m_next + 4;
        end else if (m_all && hs) begin
          m_have = 0; m_halt = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
    tick(); tick();
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else passes++;
    checks++; if (instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr); else passes++;
    checks++; if (instr_pc !== 32'd0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc); else passes++;
    checks++; if (imem_pc !== 32'd0) $display("FAIL reset_imem_pc: got %h want 0", imem_pc); else passes++;
    checks++; if ({halted, fault} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {halted, fault}); else passes++;
    checks++; if (fetch_count !== '0) $display("FAIL reset_count: got %0d want 0", fetch_count); else passes++;
  endtask

  task automatic test_stream();
    do_reset();
    tick();
    checks++; if (instr_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", instr_valid); else passes++;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== words[i])
        $display("FAIL stream_word%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, instr_valid, instr_pc, instr, 4 * i, words[i]);
      else passes++;
    end
    tick();
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) $display("FAIL stream_halt: got h=%b v=%b want h=1 v=0", halted, instr_valid); else passes++;
    checks++; if (fetch_count !== 4'd8) $display("FAIL stream_count: got %0d want 8", fetch_count); else passes++;
    checks++; if (imem_pc !== 32'h1c) $display("FAIL stream_park_pc: got %h want 1c", imem_pc); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr !== 32'h413903b3 || instr_pc !== 32'h4 || imem_pc !== 32'h8 || fetch_count !== 4'd1)
        $display("FAIL stall_hold%0d: got instr=%h pc=%h imem=%h cnt=%0d want 413903b3/4/8/1",
                 i, instr, instr_pc, imem_pc, fetch_count);
      else passes++;
    end
    instr_ready = 1;
    tick();
    checks++; if (instr_pc !== 32'h8 || fetch_count !== 4'd2) $display("FAIL stall_release: got pc=%h cnt=%0d want 8/2", instr_pc, fetch_count); else passes++;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    tick(); tick(); tick(); tick();
    checks++; if (instr_pc !== 32'h8 || fetch_count !== 4'd2) $display("FAIL redir_setup: got pc=%h cnt=%0d want 8/2", instr_pc, fetch_count); else passes++;
    redirect_valid = 1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 0;
    checks++; if (instr_valid !== 1'b0 || fetch_count !== 4'd2) $display("FAIL redir_drop: got v=%b cnt=%0d want 0/2", instr_valid, fetch_count); else passes++;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== 32'h019c1eb3) $display("FAIL redir_target: got v=%b pc=%h instr=%h want 1/10/019c1eb3", instr_valid, instr_pc, instr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h14 || fetch_count !== 4'd3) $display("FAIL redir_next: got pc=%h cnt=%0d want 14/3", instr_pc, fetch_count); else passes++;
  endtask

  task automatic test_resume_after_halt();
    for (int i = 0; i < 20 && !halted; i++) tick();
    checks++; if (halted !== 1'b1) $display("FAIL resume_reach_halt: got %b want 1", halted); else passes++;
    redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 0;
    checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) $display("FAIL resume_unhalt: got h=%b v=%b want 0/0", halted, instr_valid); else passes++;
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h00940333 || instr_pc !== 32'h0) $display("FAIL resume_word: got v=%b pc=%h instr=%h want 1/0/00940333", instr_valid, instr_pc, instr); else passes++;
    tick();
    checks++; if (instr_pc !== 32'h4) $display("FAIL resume_next: got %h want 4", instr_pc); else passes++;
  endtask

  task automatic test_fault(input logic [31:0] target);
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1; redirect_pc = target;
    tick();
    checks++; if (fault !== 1'b1 || instr_valid !== 1'b0 || imem_pc !== 32'h8) $display("FAIL fault_enter_%h: got f=%b v=%b imem=%h want 1/0/8", target, fault, instr_valid, imem_pc); else passes++;
    redirect_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'(i == 1);
      instr_ready = 1'($urandom_range(0, 1));
      tick();
    end
    redirect_valid = 0; instr_ready = 1;
    checks++; if (fault !== 1'b1 || instr_valid !== 1'b0 || imem_pc !== 32'h8) $display("FAIL fault_sticky_%h: got f=%b v=%b imem=%h want 1/0/8", target, fault, instr_valid, imem_pc); else passes++;
    reset = 1;
    tick();
    reset = 0;
    checks++; if (fault !== 1'b0) $display("FAIL fault_clear_%h: got %b want 0", target, fault); else passes++;
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL fault_restart_%h: got v=%b pc=%h want 1/0", target, instr_valid, instr_pc); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (instr_pc !== 32'hc) $display("FAIL mid_setup: got %h want c", instr_pc); else passes++;
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 || imem_pc !== 32'd0 ||
        halted !== 1'b0 || fault !== 1'b0 || fetch_count !== '0)
      $display("FAIL mid_reset: got v=%b instr=%h pc=%h imem=%h h=%b f=%b cnt=%0d want all zero",
               instr_valid, instr, instr_pc, imem_pc, halted, fault, fetch_count);
    else passes++;
    tick(); tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL mid_restart: got v=%b pc=%h want 1/0", instr_valid, instr_pc); else passes++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 12; i++) tick();
    redirect_valid = 1; redirect_pc = 32'h0;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (halted !== 1'b1 || fetch_count !== 4'hf) $display("FAIL saturate: got h=%b cnt=%0d want 1/15", halted, fetch_count); else passes++;
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = 1'($urandom_range(0, m_fault ? 7 : 149) == 0);
      instr_ready = 1'($urandom_range(0, 9) < 7);
      redirect_valid = 1'($urandom_range(0, 11) == 0);
      sel = int'($urandom_range(0, 9));
      if (sel < 6) redirect_pc = 32'($urandom_range(0, 7) * 4);
      else if (sel < 8) redirect_pc = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else if (sel == 8) redirect_pc = 32'(MemBytes + $urandom_range(0, 50) * 4);
      else redirect_pc = 32'hffff_fffc;
      tick();
      checks++;
      if (instr_valid !== m_have || imem_pc !== m_next || halted !== m_halt || fault !== m_fault ||
          fetch_count !== m_count)
        $display("FAIL rand_status@%0d: got v=%b imem=%h h=%b f=%b cnt=%0d want v=%b imem=%h h=%b f=%b cnt=%0d",
                 cyc, instr_valid, imem_pc, halted, fault, fetch_count,
                 m_have, m_next, m_halt, m_fault, m_count);
      else passes++;
      if (m_have) begin
        checks++;
        if (instr_pc !== m_wpc || instr !== words[m_wpc[4:2]])
          $display("FAIL rand_word@%0d: got pc=%h instr=%h want pc=%h instr=%h",
                   cyc, instr_pc, instr, m_wpc, words[m_wpc[4:2]]);
        else passes++;
      end
    end
    reset = 0; redirect_valid = 0;
  endtask

  initial begin
    words[0] = 32'h00940333; words[1] = 32'h413903b3; words[2] = 32'h035a02b3;
    words[3] = 32'h017b4e33; words[4] = 32'h019c1eb3; words[5] = 32'h41de8f33;
    words[6] = 32'h00a50533; words[7] = 32'h0000006f;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_resume_after_halt();
    test_fault(32'h6);
    test_fault(32'h20);
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
